// File: rtl/jtag_debug_cmd_bridge_if.sv
// Bundles the TCK-side shift-chain strobes, the per-channel debug handshake and
// the status outputs of the JTAG debug command bridge.
interface jtag_debug_cmd_bridge_if #(
    parameter int SR_WIDTH   = 38,
    parameter int IR_WIDTH   = 2,
    parameter int NUM_CH     = 4,
    parameter int FIFO_DEPTH = 4
);
    localparam int PW = $clog2(FIFO_DEPTH) + 1;

    logic                vs_udr;
    logic                vs_uir;
    logic [IR_WIDTH-1:0] ir_in;
    logic [SR_WIDTH-1:0] sr;
    logic [NUM_CH-1:0]   ch_ready;
    logic                ovf_clr;
    logic [SR_WIDTH-1:0] jdo;
    logic [NUM_CH-1:0]   take_action;
    logic [NUM_CH-1:0]   take_no_action;
    logic                ir_update;
    logic [IR_WIDTH-1:0] ir_q;
    logic [PW-1:0]       pending;
    logic                ovf;

    modport slave (
        input  vs_udr, vs_uir, ir_in, sr, ch_ready, ovf_clr,
        output jdo, take_action, take_no_action, ir_update, ir_q, pending, ovf
    );

    modport master (
        output vs_udr, vs_uir, ir_in, sr, ch_ready, ovf_clr,
        input  jdo, take_action, take_no_action, ir_update, ir_q, pending, ovf
    );
endinterface

// File: rtl/jtag_debug_cmd_bridge.sv
// Synchronises virtual-JTAG update strobes into clk, queues decoded commands and
// issues them in order as take_action / take_no_action pulses per channel.
module jtag_debug_cmd_bridge #(
    parameter int SR_WIDTH    = 38,
    parameter int IR_WIDTH    = 2,
    parameter int NUM_CH      = 4,
    parameter int SYNC_STAGES = 2,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    jtag_debug_cmd_bridge_if.slave bus
);
    localparam int AW  = $clog2(FIFO_DEPTH);
    localparam int PW  = AW + 1;
    localparam int CHW = IR_WIDTH + 1;
    localparam int SCW = $clog2(SYNC_STAGES + 1);

    typedef struct packed {
        logic [IR_WIDTH-1:0] ch;
        logic [SR_WIDTH-1:0] sr;
    } cmd_t;

    logic [1:0] raw_w;
    logic [1:0] evt_w;
    logic       settled_w;
    logic [SCW-1:0] settle_q, settle_d;

    assign raw_w     = {bus.vs_uir, bus.vs_udr};
    assign settled_w = (settle_q == SCW'(SYNC_STAGES));

    // Arming waits until the chain has been refilled since reset, so a strobe
    // held high through reset release is never mistaken for a fresh rise.
    always_comb begin
        settle_d = settled_w ? settle_q : settle_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            settle_q <= '0;
        end else begin
            settle_q <= settle_d;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_sync
            logic [SYNC_STAGES-1:0] sync_q, sync_d;
            logic prev_q, prev_d;
            logic armed_q, armed_d;
            logic evt_q, evt_d;

            always_comb begin
                sync_d  = {sync_q[SYNC_STAGES-2:0], raw_w[gi]};
                prev_d  = sync_q[SYNC_STAGES-1];
                armed_d = armed_q | (settled_w & ~sync_q[SYNC_STAGES-1]);
                evt_d   = sync_q[SYNC_STAGES-1] & ~prev_q & armed_q;
            end

            always_ff @(posedge clk) begin
                if (reset) begin
                    sync_q  <= '0;
                    prev_q  <= 1'b0;
                    armed_q <= 1'b0;
                    evt_q   <= 1'b0;
                end else begin
                    sync_q  <= sync_d;
                    prev_q  <= prev_d;
                    armed_q <= armed_d;
                    evt_q   <= evt_d;
                end
            end

            assign evt_w[gi] = evt_q;
        end
    endgenerate

    cmd_t                mem_q [FIFO_DEPTH];
    logic [PW-1:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [SR_WIDTH-1:0] jdo_q, jdo_d;
    logic [NUM_CH-1:0]   take_action_q, take_action_d;
    logic [NUM_CH-1:0]   take_no_action_q, take_no_action_d;
    logic [IR_WIDTH-1:0] ir_q_q, ir_q_d;
    logic                ovf_q, ovf_d;

    logic [PW-1:0]     count_w;
    logic              empty_w, full_w, in_range_w;
    logic              push_req_w, push_w, pop_w, drop_w;
    cmd_t              head_w;
    logic [NUM_CH-1:0] head_onehot_w;

    assign count_w    = wr_ptr_q - rd_ptr_q;
    assign empty_w    = (count_w == '0);
    assign full_w     = (count_w == PW'(FIFO_DEPTH));
    assign head_w     = mem_q[rd_ptr_q[AW-1:0]];
    assign in_range_w = ({1'b0, bus.ir_in} < CHW'(NUM_CH));

    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_head_sel
            assign head_onehot_w[gi] = (head_w.ch == IR_WIDTH'(gi));
        end
    endgenerate

    // A full queue still accepts a push when the head leaves in the same cycle.
    assign push_req_w = evt_w[0] & in_range_w;
    assign pop_w      = ~empty_w & (|(bus.ch_ready & head_onehot_w));
    assign push_w     = push_req_w & (~full_w | pop_w);
    assign drop_w     = push_req_w & full_w & ~pop_w;

    always_comb begin
        wr_ptr_d         = push_w ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d         = pop_w ? rd_ptr_q + 1'b1 : rd_ptr_q;
        jdo_d            = pop_w ? head_w.sr : jdo_q;
        take_action_d    = (pop_w & head_w.sr[SR_WIDTH-1]) ? head_onehot_w : '0;
        take_no_action_d = (pop_w & ~head_w.sr[SR_WIDTH-1]) ? head_onehot_w : '0;
        ir_q_d           = evt_w[1] ? bus.ir_in : ir_q_q;
        ovf_d            = drop_w | (ovf_q & ~bus.ovf_clr);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q         <= '0;
            rd_ptr_q         <= '0;
            jdo_q            <= '0;
            take_action_q    <= '0;
            take_no_action_q <= '0;
            ir_q_q           <= '0;
            ovf_q            <= 1'b0;
        end else begin
            wr_ptr_q         <= wr_ptr_d;
            rd_ptr_q         <= rd_ptr_d;
            jdo_q            <= jdo_d;
            take_action_q    <= take_action_d;
            take_no_action_q <= take_no_action_d;
            ir_q_q           <= ir_q_d;
            ovf_q            <= ovf_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_w) begin
            mem_q[wr_ptr_q[AW-1:0]] <= {bus.ir_in, bus.sr};
        end
    end

    assign bus.jdo            = jdo_q;
    assign bus.take_action    = take_action_q;
    assign bus.take_no_action = take_no_action_q;
    assign bus.ir_update      = evt_w[1];
    assign bus.ir_q           = ir_q_q;
    assign bus.pending        = count_w;
    assign bus.ovf            = ovf_q;
endmodule

// File: tb/tb_jtag_debug_cmd_bridge.sv
// Directed and randomised checks of the JTAG debug command bridge against an
// in-order command queue model.
module tb_jtag_debug_cmd_bridge;
    localparam int SRW   = 38;
    localparam int IRW   = 2;
    localparam int NCH   = 4;
    localparam int SYNC  = 2;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    jtag_debug_cmd_bridge_if #(.SR_WIDTH(SRW), .IR_WIDTH(IRW), .NUM_CH(NCH), .FIFO_DEPTH(DEPTH)) bus ();
    jtag_debug_cmd_bridge_if #(.SR_WIDTH(SRW), .IR_WIDTH(IRW), .NUM_CH(3), .FIFO_DEPTH(DEPTH)) bus3 ();

    jtag_debug_cmd_bridge #(.SR_WIDTH(SRW), .IR_WIDTH(IRW), .NUM_CH(NCH),
                            .SYNC_STAGES(SYNC), .FIFO_DEPTH(DEPTH))
        dut (.clk(clk), .reset(reset), .bus(bus));

    jtag_debug_cmd_bridge #(.SR_WIDTH(SRW), .IR_WIDTH(IRW), .NUM_CH(3),
                            .SYNC_STAGES(SYNC), .FIFO_DEPTH(DEPTH))
        dut3 (.clk(clk), .reset(reset), .bus(bus3));

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [IRW-1:0] ch;
        logic [SRW-1:0] sr;
    } cmd_t;
    cmd_t exp_q[$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: every pulse must match the oldest accepted command.
    always @(negedge clk) begin : monitor
        cmd_t e;
        logic [NCH-1:0] ea, ena;
        if (bus.take_action !== '0 || bus.take_no_action !== '0) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_pulse", {bus.take_action, bus.take_no_action}, 64'h0);
            end else begin
                e   = exp_q.pop_front();
                ea  = e.sr[SRW-1] ? (NCH'(1) << e.ch) : '0;
                ena = e.sr[SRW-1] ? '0 : (NCH'(1) << e.ch);
                chk("issue_take_action", bus.take_action, ea);
                chk("issue_take_no_action", bus.take_no_action, ena);
                chk("issue_jdo", bus.jdo, e.sr);
                $display("issue ch=%0d action=%0d jdo=%h", e.ch, e.sr[SRW-1], bus.jdo);
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1);
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send(input logic [IRW-1:0] ch, input logic [SRW-1:0] v,
                        input bit accept, input bit rnd);
        cmd_t c;
        c.ch = ch;
        c.sr = v;
        bus.ir_in  = ch;
        bus.sr     = v;
        bus.vs_udr = 1'b1;
        if (accept) exp_q.push_back(c);
        repeat (4) begin
            @(negedge clk);
            if (rnd) bus.ch_ready = NCH'($urandom);
        end
        bus.vs_udr = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (rnd) bus.ch_ready = NCH'($urandom);
        end
    endtask

    task automatic wait_drain(input string tag);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk(tag, exp_q.size(), 0);
        chk({tag, "_pending"}, bus.pending, 0);
    endtask

    initial begin : stim
        int upd_cnt, pulse_cnt, found, n;
        logic [63:0] r;
        logic [SRW-1:0] pulses;

        bus.vs_udr = 0; bus.vs_uir = 0; bus.ir_in = 0; bus.sr = 0;
        bus.ch_ready = 0; bus.ovf_clr = 0;
        bus3.vs_udr = 0; bus3.vs_uir = 0; bus3.ir_in = 0; bus3.sr = 0;
        bus3.ch_ready = '1; bus3.ovf_clr = 0;
        reset = 1'b1;
        tick(3);
        reset = 1'b0;
        tick(4);

        chk("rst_pending", bus.pending, 0);
        chk("rst_ovf", bus.ovf, 0);
        chk("rst_jdo", bus.jdo, 0);
        chk("rst_ir_q", bus.ir_q, 0);
        chk("rst_pulses", {bus.take_action, bus.take_no_action, bus.ir_update}, 0);

        // Basic issue: pulse five cycles after the raw rise.
        bus.ch_ready = '1;
        begin
            cmd_t c;
            c.ch = 2; c.sr = 38'h20_0000_1234;
            exp_q.push_back(c);
        end
        bus.ir_in = 2; bus.sr = 38'h20_0000_1234; bus.vs_udr = 1;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (k == 4) bus.vs_udr = 0;
            chk($sformatf("basic_ta_k%0d", k), bus.take_action, (k == 5) ? 4'b0100 : 4'b0000);
        end
        chk("basic_jdo", bus.jdo, 38'h20_0000_1234);
        chk("basic_pending", bus.pending, 0);
        tick(2);

        // Backpressure and overflow.
        bus.ch_ready = '0;
        for (int k = 1; k <= 5; k++) send(IRW'(1), SRW'(k), k <= 4, 0);
        chk("ovf_pending", bus.pending, 4);
        chk("ovf_set", bus.ovf, 1);
        bus.ch_ready = 4'b0010;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            chk($sformatf("ovf_tna_k%0d", k), bus.take_no_action, (k <= 4) ? 4'b0010 : 4'b0000);
            if (k <= 4) chk($sformatf("ovf_jdo_k%0d", k), bus.jdo, k);
        end
        chk("ovf_drained", bus.pending, 0);
        chk("ovf_sticky", bus.ovf, 1);
        bus.ovf_clr = 1;
        tick(1);
        bus.ovf_clr = 0;
        chk("ovf_cleared", bus.ovf, 0);

        // Head-of-line blocking.
        bus.ch_ready = 4'b1000;
        send(IRW'(0), 38'h20_0000_00A0, 1, 0);
        send(IRW'(3), 38'h00_0000_00B3, 1, 0);
        chk("hol_pending", bus.pending, 2);
        chk("hol_no_pulse", {bus.take_action, bus.take_no_action}, 0);
        bus.ch_ready = '1;
        tick(1);
        chk("hol_first_ch0", bus.take_action, 4'b0001);
        tick(1);
        chk("hol_second_ch3", bus.take_no_action, 4'b1000);
        chk("hol_second_no_ta", bus.take_action, 4'b0000);
        wait_drain("hol_drain");

        // Reset with strobe held high.
        bus.ch_ready = '0;
        for (int k = 0; k < 3; k++) send(IRW'(2), SRW'(16 + k), 1, 0);
        chk("rsth_pending_before", bus.pending, 3);
        bus.ir_in = 2; bus.sr = 38'h20_0000_0777; bus.vs_udr = 1;
        tick(1);
        reset = 1;
        exp_q.delete();
        tick(2);
        reset = 0;
        bus.ch_ready = '1;
        pulses = '0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            pulses = pulses | SRW'({bus.take_action, bus.take_no_action});
        end
        chk("rsth_no_pulse", pulses, 0);
        chk("rsth_pending", bus.pending, 0);
        chk("rsth_ovf", bus.ovf, 0);
        bus.vs_udr = 0;
        tick(4);
        send(IRW'(2), 38'h20_0000_0888, 1, 0);
        wait_drain("rsth_fresh");

        // Simultaneous UIR/UDR rise.
        begin
            cmd_t c;
            c.ch = 1; c.sr = 38'h00_0000_0051;
            exp_q.push_back(c);
        end
        bus.ir_in = 1; bus.sr = 38'h00_0000_0051; bus.vs_udr = 1; bus.vs_uir = 1;
        upd_cnt = 0;
        pulse_cnt = 0;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (k == 4) begin
                bus.vs_udr = 0;
                bus.vs_uir = 0;
            end
            if (bus.ir_update === 1'b1) upd_cnt++;
            if (bus.take_no_action !== '0) pulse_cnt++;
        end
        chk("simul_ir_update_count", upd_cnt, 1);
        chk("simul_ir_q", bus.ir_q, 1);
        chk("simul_issue_count", pulse_cnt, 1);
        wait_drain("simul_drain");

        // Out-of-range IR on the three-channel instance.
        bus3.ir_in = 3; bus3.sr = 38'h20_0000_0003; bus3.vs_udr = 1;
        pulses = '0;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (k == 4) bus3.vs_udr = 0;
            pulses = pulses | SRW'({bus3.take_action, bus3.take_no_action});
        end
        chk("oor_no_pulse", pulses, 0);
        chk("oor_ovf", bus3.ovf, 0);
        chk("oor_pending", bus3.pending, 0);
        bus3.ir_in = 2; bus3.sr = 38'h00_0000_0002; bus3.vs_udr = 1;
        found = 0;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (k == 4) bus3.vs_udr = 0;
            if (bus3.take_no_action === 3'b100) found++;
        end
        chk("oor_inrange_issue", found, 1);

        // Full FIFO with push and pop in the same cycle.
        bus.ch_ready = '0;
        for (int k = 0; k < 4; k++) send(IRW'(2), SRW'(38'h100 + k), 1, 0);
        chk("fpp_pending_full", bus.pending, 4);
        begin
            cmd_t c;
            c.ch = 3; c.sr = 38'h20_0000_0ABC;
            exp_q.push_back(c);
        end
        bus.ir_in = 3; bus.sr = 38'h20_0000_0ABC; bus.vs_udr = 1;
        tick(3);
        bus.ch_ready = 4'b0100;
        tick(1);
        bus.ch_ready = '0;
        chk("fpp_pending_kept", bus.pending, 4);
        chk("fpp_ovf", bus.ovf, 0);
        chk("fpp_head_pulse", bus.take_no_action, 4'b0100);
        bus.vs_udr = 0;
        tick(4);
        bus.ch_ready = '1;
        wait_drain("fpp_drain");

        // Randomised commands under random per-cycle readiness.
        for (int i = 0; i < 40; i++) begin
            n = 0;
            while (exp_q.size() >= DEPTH && n < 100) begin
                @(negedge clk);
                bus.ch_ready = NCH'($urandom);
                n++;
            end
            chk("rand_room", exp_q.size() < DEPTH, 1);
            r = {$urandom, $urandom};
            send(IRW'($urandom_range(0, NCH - 1)), r[SRW-1:0], 1, 1);
        end
        bus.ch_ready = '1;
        wait_drain("rand_drain");
        chk("rand_ovf", bus.ovf, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
